// File: rtl/reg_bridge_pkg.sv
// Shared constants and types for the host-side register bridge and the PID register file.
// Opcodes, response bytes, register map and the bridge FSM state encoding live here.
package reg_bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    // Register map, also used by the register-file block.
    localparam logic [7:0] REG_P     = 8'd0;
    localparam logic [7:0] REG_I     = 8'd1;
    localparam logic [7:0] REG_D     = 8'd2;
    localparam logic [7:0] REG_SP    = 8'd3;
    localparam logic [7:0] REG_PID_O = 8'd4;
    localparam logic [7:0] REG_PWM_O = 8'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_DATA     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RD_ISSUE = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_RESP     = 3'd6
    } state_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_t;

    function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned max_addr);
        return 32'(addr) <= max_addr;
    endfunction

endpackage

// File: rtl/reg_bridge.sv
// Byte-stream command decoder: parses 'W' addr data / 'R' addr frames from the UART
// receiver, drives the register-file ports and returns ACK/NAK or read data to the transmitter.
module reg_bridge
    import reg_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned WR_MAX  = 3,
    parameter int unsigned RD_MAX  = 5
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       write_enable,
    output logic [7:0] w_addr,
    output logic [7:0] w_data,
    output logic [7:0] r_addr,
    input  logic [7:0] r_data_i,
    output logic       busy,
    output logic       overrun,
    output state_t     o_dbg_state
);

    // Handshake: the response byte is offered with tx_valid and is transferred on the
    // cycle where tx_valid && tx_ready; tx_valid and tx_data then hold until that cycle.
    // rx_valid is a one-cycle strobe with no backpressure: bytes arriving while the
    // bridge is not listening are dropped and flagged on overrun.

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    state_t          r_state;
    op_t             r_op;
    logic [7:0]      r_frame_addr;
    logic            r_tx_valid;
    logic [7:0]      r_tx_data;
    logic            r_we;
    logic [7:0]      r_w_addr;
    logic [7:0]      r_w_data;
    logic [7:0]      r_r_addr;
    logic            r_overrun;
    logic [CW-1:0]   r_timeout_cnt;

    logic            w_listening;
    logic            w_timed_out;

    assign w_listening = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_timed_out = (r_timeout_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_WRITE;
            r_frame_addr  <= 8'h00;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_we          <= 1'b0;
            r_w_addr      <= 8'h00;
            r_w_data      <= 8'h00;
            r_r_addr      <= 8'h00;
            r_overrun     <= 1'b0;
            r_timeout_cnt <= '0;
        end else begin
            r_we          <= 1'b0;
            r_timeout_cnt <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_WR) begin
                            r_op    <= OP_WRITE;
                            r_state <= ST_ADDR;
                        end else if (rx_data == CMD_RD) begin
                            r_op    <= OP_READ;
                            r_state <= ST_ADDR;
                        end else begin
                            r_tx_data  <= RSP_NAK;
                            r_tx_valid <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                    end
                end

                ST_ADDR: begin
                    if (rx_valid) begin
                        r_frame_addr <= rx_data;
                        if ((r_op == OP_READ) && addr_in_range(rx_data, RD_MAX)) begin
                            r_r_addr <= rx_data;
                            r_state  <= ST_RD_ISSUE;
                        end else if ((r_op == OP_WRITE) && addr_in_range(rx_data, WR_MAX)) begin
                            r_state <= ST_DATA;
                        end else begin
                            // A rejected write does not wait for its data byte.
                            r_tx_data  <= RSP_NAK;
                            r_tx_valid <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                    end else if (w_timed_out) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (rx_valid) begin
                        r_we     <= 1'b1;
                        r_w_addr <= r_frame_addr;
                        r_w_data <= rx_data;
                        r_state  <= ST_WRITE;
                    end else if (w_timed_out) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
                    end
                end

                ST_WRITE: begin
                    r_tx_data  <= RSP_ACK;
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_RESP;
                end

                ST_RD_ISSUE: begin
                    r_state <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    r_tx_data  <= r_data_i;
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_RESP;
                end

                ST_RESP: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase

            // Includes a byte landing in the same cycle the TX handshake completes.
            if (rx_valid && !w_listening) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // The strobe is masked by reset so a reset in the WRITE cycle suppresses the write.
    assign write_enable = r_we && !reset;
    assign w_addr       = r_w_addr;
    assign w_data       = r_w_data;
    assign r_addr       = r_r_addr;
    assign tx_valid     = r_tx_valid;
    assign tx_data      = r_tx_data;
    assign overrun      = r_overrun;
    assign busy         = (r_state != ST_IDLE);
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_reg_bridge.sv
// Directed bench for reg_bridge: a stimulus thread issues frames and pushes expected
// responses/writes; a monitor pops and compares whenever the DUT presents a byte or write.
module tb_reg_bridge;
  import reg_bridge_pkg::*;

  localparam int TIMEOUT = 1000;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b1;
  logic [7:0] r_data_i = 8'h00;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       write_enable;
  logic [7:0] w_addr;
  logic [7:0] w_data;
  logic [7:0] r_addr;
  logic       busy;
  logic       overrun;
  state_t     dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_wr_q[$];
  logic [7:0]  mon_exp;
  logic [15:0] mon_wr_exp;

  // Register-file model: registered read, initial contents chosen per test.
  logic [7:0] regs [0:5] = '{8'h00, 8'h33, 8'h44, 8'h00, 8'h00, 8'hC4};

  reg_bridge #(.TIMEOUT(TIMEOUT), .WR_MAX(3), .RD_MAX(5)) dut (
    .clk_in(clk_in), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .write_enable(write_enable), .w_addr(w_addr), .w_data(w_data),
    .r_addr(r_addr), .r_data_i(r_data_i), .busy(busy), .overrun(overrun),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (write_enable) regs[w_addr[2:0]] <= w_data;
    r_data_i <= (r_addr <= 8'd5) ? regs[r_addr[2:0]] : 8'h00;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk_in) begin
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: got %02h, expected no response", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", {8'h00, tx_data}, {8'h00, mon_exp});
      end
    end
    if (write_enable) begin
      if (exp_wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_unexpected: got addr %02h data %02h, expected no write", w_addr, w_data);
      end else begin
        mon_wr_exp = exp_wr_q.pop_front();
        check("wr_addr_data", {w_addr, w_data}, mon_wr_exp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || tx_valid !== 1'b0) && n < 100) begin
      tick();
      n++;
    end
    check(name, {15'd0, busy}, 16'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable;
    tick();
    tick();
    check("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    check("rst_tx_data", {8'h00, tx_data}, 16'h00);
    check("rst_write_enable", {15'd0, write_enable}, 16'd0);
    check("rst_w_addr", {8'h00, w_addr}, 16'h00);
    check("rst_w_data", {8'h00, w_data}, 16'h00);
    check("rst_r_addr", {8'h00, r_addr}, 16'h00);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_overrun", {15'd0, overrun}, 16'd0);
    reset = 1'b0;
    tick();

    // write 0x2A to P, then read it back
    exp_wr_q.push_back({8'h00, 8'h2A});
    exp_q.push_back(RSP_ACK);
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h2A);
    check("wr_pulse", {15'd0, write_enable}, 16'd1);
    check("wr_w_addr", {8'h00, w_addr}, 16'h00);
    check("wr_w_data", {8'h00, w_data}, 16'h2A);
    check("wr_no_early_ack", {15'd0, tx_valid}, 16'd0);
    tick();
    check("wr_pulse_one_cycle", {15'd0, write_enable}, 16'd0);
    check("wr_ack_valid", {15'd0, tx_valid}, 16'd1);
    check("wr_ack_data", {8'h00, tx_data}, {8'h00, RSP_ACK});
    wait_idle("wr_idle");

    exp_q.push_back(8'h2A);
    send_byte(8'h52);
    send_byte(8'h00);
    check("rd_r_addr", {8'h00, r_addr}, 16'h00);
    check("rd_lat_t1", {15'd0, tx_valid}, 16'd0);
    tick();
    check("rd_lat_t2", {15'd0, tx_valid}, 16'd0);
    tick();
    check("rd_lat_t3", {15'd0, tx_valid}, 16'd1);
    check("rd_data", {8'h00, tx_data}, 16'h2A);
    wait_idle("rd_idle");

    // write to read-only address: NAK right after addr, trailing byte NAKs again
    exp_q.push_back(RSP_NAK);
    send_byte(8'h57);
    send_byte(8'h04);
    check("ro_nak_valid", {15'd0, tx_valid}, 16'd1);
    check("ro_nak_data", {8'h00, tx_data}, {8'h00, RSP_NAK});
    tick();
    exp_q.push_back(RSP_NAK);
    send_byte(8'h11);
    check("trail_nak_valid", {15'd0, tx_valid}, 16'd1);
    wait_idle("ro_idle");

    // read out of range
    exp_q.push_back(RSP_NAK);
    send_byte(8'h52);
    send_byte(8'h07);
    check("rd_oor_nak", {8'h00, tx_data}, {8'h00, RSP_NAK});
    check("rd_oor_r_addr_held", {8'h00, r_addr}, 16'h00);
    wait_idle("rd_oor_idle");

    // bad opcode
    exp_q.push_back(RSP_NAK);
    send_byte(8'hFF);
    check("bad_op_nak_valid", {15'd0, tx_valid}, 16'd1);
    check("bad_op_busy", {15'd0, busy}, 16'd1);
    tick();
    check("bad_op_busy_clear", {15'd0, busy}, 16'd0);
    check("bad_op_tx_clear", {15'd0, tx_valid}, 16'd0);
    tick();

    // timeout in DATA
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (TIMEOUT - 2) tick();
    check("to_not_early", {15'd0, busy}, 16'd1);
    repeat (2) tick();
    check("to_busy_clear", {15'd0, busy}, 16'd0);
    check("to_no_tx", {15'd0, tx_valid}, 16'd0);
    check("to_overrun_clear", {15'd0, overrun}, 16'd0);
    exp_q.push_back(8'h33);
    send_byte(8'h52);
    send_byte(8'h01);
    tick();
    tick();
    check("to_then_read_valid", {15'd0, tx_valid}, 16'd1);
    check("to_then_read_data", {8'h00, tx_data}, 16'h33);
    wait_idle("to_idle");

    // backpressure with dropped bytes
    tx_ready = 1'b0;
    exp_q.push_back(8'hC4);
    send_byte(8'h52);
    send_byte(8'h05);
    tick();
    tick();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5 || i == 12) begin
        rx_valid = 1'b1;
        rx_data  = (i == 5) ? 8'h52 : 8'h57;
      end
      if (tx_valid !== 1'b1 || tx_data !== 8'hC4) stable = 1'b0;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
    check("bp_tx_stable", {15'd0, stable}, 16'd1);
    check("bp_overrun", {15'd0, overrun}, 16'd1);
    tx_ready = 1'b1;
    tick();
    check("bp_bytes_ignored", {15'd0, busy}, 16'd0);
    check("bp_overrun_sticky", {15'd0, overrun}, 16'd1);
    tick();

    // reset in the cycle after the data byte
    send_byte(8'h57);
    send_byte(8'h02);
    send_byte(8'h55);
    reset = 1'b1;
    #1;
    check("rst_mid_no_we", {15'd0, write_enable}, 16'd0);
    tick();
    check("rst_mid_tx_valid", {15'd0, tx_valid}, 16'd0);
    check("rst_mid_busy", {15'd0, busy}, 16'd0);
    check("rst_mid_overrun", {15'd0, overrun}, 16'd0);
    check("rst_mid_addrs", {w_addr, r_addr}, 16'h0000);
    check("rst_mid_w_data", {8'h00, w_data}, 16'h00);
    check("rst_mid_tx_data", {8'h00, tx_data}, 16'h00);
    reset = 1'b0;
    tick();
    exp_q.push_back(8'h44);
    send_byte(8'h52);
    send_byte(8'h02);
    tick();
    tick();
    check("rst_mid_reg_unchanged", {8'h00, tx_data}, 16'h44);
    wait_idle("final_idle");

    check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    check("exp_wr_q_drained", 16'(exp_wr_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bridge.md
# reg_bridge

Byte-stream command decoder that acts as the host-side initiator for the PID register file. It takes bytes from the UART receiver, parses write and read frames, and drives the register file's write port and registered read port. It returns an acknowledge byte or the read data through a valid/ready transmit handshake. It sits between the UART RX/TX pair and the register-file memory block.

## Interface
- `TIMEOUT`, default 1000: cycles without `rx_valid` in a mid-frame state before the frame is abandoned; must be ≥ 2.
- `WR_MAX`, default 3: highest writable address (P, I, D, SP).
- `RD_MAX`, default 5: highest readable address (adds PID_O, PWM_O).
- `clk_in` input 1: clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `rx_valid` input 1: one-cycle strobe, `rx_data` valid; no backpressure.
- `rx_data` input 8: received byte.
- `tx_valid` output 1: response byte available; held until accepted.
- `tx_ready` input 1: TX accepts the byte when `tx_valid && tx_ready`.
- `tx_data` output 8: response byte; stable while `tx_valid` is high.
- `write_enable` output 1: one-cycle register-file write strobe.
- `w_addr` output 8: write address.
- `w_data` output 8: write data.
- `r_addr` output 8: read address.
- `r_data_i` input 8: register-file read data, valid one cycle after `r_addr` is sampled.
- `busy` output 1: high in every state except IDLE.
- `overrun` output 1: sticky; set when an `rx_valid` byte is dropped; cleared only by `reset`.

## Operation
- Frames:
  - Write: `0x57` ('W'), addr, data. Response: ACK `0x06`.
  - Read: `0x52` ('R'), addr. Response: one data byte.
- States: IDLE, ADDR, DATA, WRITE, RD_ISSUE, RD_WAIT, RESP.
- IDLE, on `rx_valid`:
  - `0x57` → ADDR with op = write.
  - `0x52` → ADDR with op = read.
  - Any other byte → load NAK `0x15` → RESP.
- ADDR, on `rx_valid`, the address is latched, then:
  - Read with addr ≤ `RD_MAX` → RD_ISSUE.
  - Write with addr ≤ `WR_MAX` → DATA.
  - Otherwise → NAK → RESP. For a write, the data byte is not awaited.
- DATA, on `rx_valid`: latch data → WRITE.
- WRITE: `write_enable` = 1 for exactly this cycle, with `w_addr`/`w_data` = latched values. Load ACK → RESP.
- RD_ISSUE: `r_addr` holds the address. Next state RD_WAIT.
- RD_WAIT: capture `r_data_i` into `tx_data` → RESP.
- RESP: `tx_valid` = 1. On `tx_ready` → IDLE.
- `w_addr`, `w_data` and `r_addr` hold their last values outside WRITE and RD_ISSUE.
- Dropped bytes: `rx_valid` in WRITE, RD_ISSUE, RD_WAIT or RESP drops the byte and sets `overrun`. This includes a byte arriving in the same cycle the TX handshake completes.
- Timeout:
  - The counter clears on every `rx_valid` and in every state other than ADDR/DATA.
  - It increments in ADDR/DATA cycles without `rx_valid`.
  - When it reaches `TIMEOUT`−1 → IDLE. No response, no write, `overrun` unchanged.
- Reset mid-frame: → IDLE on the next edge.
  - No write pulse and no response.
  - A pending `tx_valid` is withdrawn.

## Timing
- Reset values: state IDLE; `tx_valid`, `tx_data`, `write_enable`, `w_addr`, `w_data`, `r_addr`, `busy`, `overrun` and the timeout counter all 0.
- Write, data byte strobed in cycle t:
  - `write_enable` high in t+1.
  - `tx_valid` (ACK) high from t+2.
- Read, addr byte strobed in cycle t:
  - `r_addr` valid in t+1.
  - `r_data_i` sampled at the end of t+2.
  - `tx_valid` with data high from t+3.
- NAK: `tx_valid` high the cycle after the offending byte.
- `tx_valid` never drops without a handshake, except on `reset`.
- Back-to-back frames: the next command byte is accepted from the cycle after the TX handshake. Minimum frame spacing is 1 idle cycle.
- Timeout counter width: `$clog2(TIMEOUT)`.

## Structure
- Package `reg_bridge_pkg` holds:
  - Opcodes `CMD_WR`=`0x57`, `CMD_RD`=`0x52`, `RSP_ACK`=`0x06`, `RSP_NAK`=`0x15`.
  - The state enum.
  - Register-address constants REG_P..REG_PWM_O (0..5), shared with the register file.
- Single module. The timeout counter is inline; no sub-module is warranted.

## Test plan
- Write then read: `57 00 2A` → `write_enable` 1 cycle with addr 0, data `0x2A`; `tx_data=06`. Then `52 00` → `tx_data=2A` three cycles after the addr byte.
- Read-only/out-of-range:
  - `57 04 11` → NAK after the addr byte, no `write_enable`; the trailing `11` produces a second NAK.
  - `52 07` → NAK.
- Bad opcode `0xFF` → NAK the next cycle. `busy` returns to 0 after the handshake.
- Timeout: `57 01`, then silence for `TIMEOUT` cycles → `busy`=0, no write, no `tx_valid`. A following `52 01` works normally.
- Backpressure/overrun: hold `tx_ready`=0 for 20 cycles during a read response and strobe 2 bytes → `tx_data` stays stable, `overrun`=1, and both bytes are ignored.
- Reset asserted in the cycle after the DATA byte → no `write_enable` pulse, `tx_valid`=0, and all outputs at reset values.
